// File: rtl/serv_alu_wide_if.sv
// Chunked ALU handshake bundle: controls and operand chunks in, result chunk and status out.
interface serv_alu_wide_if #(parameter int W = 1);
  localparam int N  = 32 / W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic          i_start;
  logic          i_sub;
  logic [1:0]    i_bool_op;
  logic          i_cmp_eq;
  logic          i_cmp_sig;
  logic [2:0]    i_rd_sel;
  logic [W-1:0]  i_rs1;
  logic [W-1:0]  i_op_b;
  logic [W-1:0]  i_buf;
  logic [W-1:0]  o_rd;
  logic          o_busy;
  logic [CW-1:0] o_cnt;
  logic          o_done;
  logic          o_cmp;

  modport master (
    output i_start, i_sub, i_bool_op, i_cmp_eq, i_cmp_sig, i_rd_sel,
           i_rs1, i_op_b, i_buf,
    input  o_rd, o_busy, o_cnt, o_done, o_cmp
  );

  modport slave (
    input  i_start, i_sub, i_bool_op, i_cmp_eq, i_cmp_sig, i_rd_sel,
           i_rs1, i_op_b, i_buf,
    output o_rd, o_busy, o_cnt, o_done, o_cmp
  );
endinterface

// File: rtl/serv_alu_wide.sv
// W-bit-per-cycle ALU: walks a 32-bit operation LSB-first over 32/W chunks,
// carrying adder carry and equality state between chunks.
module serv_alu_wide #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           i_rst,
  serv_alu_wide_if.slave alu
);
  localparam int N  = 32 / W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_r, state_nx;
  logic          sub_r, cmp_eq_r, cmp_sig_r;
  logic [1:0]    bool_op_r;
  logic [2:0]    rd_sel_r;
  logic          carry_r, eq_r, done_r, cmp_r;
  logic [CW-1:0] cnt_r;

  logic          busy, start_acc, last;
  logic [W-1:0]  b_inv, sum, bool_res, sel1_term, rd_run;
  logic [W:0]    add_full;
  logic          cy, sum_zero, rs1_sx, b_sx, lt;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_r   <= IDLE;
      sub_r     <= 1'b0;
      bool_op_r <= 2'b00;
      cmp_eq_r  <= 1'b0;
      cmp_sig_r <= 1'b0;
      rd_sel_r  <= 3'b000;
      carry_r   <= 1'b0;
      eq_r      <= 1'b1;
      cnt_r     <= '0;
      done_r    <= 1'b0;
      cmp_r     <= 1'b0;
    end else begin
      state_r <= state_nx;
      done_r  <= last;
      if (start_acc) begin
        sub_r     <= alu.i_sub;
        bool_op_r <= alu.i_bool_op;
        cmp_eq_r  <= alu.i_cmp_eq;
        cmp_sig_r <= alu.i_cmp_sig;
        rd_sel_r  <= alu.i_rd_sel;
        carry_r   <= alu.i_sub;
        eq_r      <= 1'b1;
        cnt_r     <= '0;
      end else if (busy) begin
        carry_r <= cy;
        eq_r    <= eq_r & sum_zero;
        cnt_r   <= cnt_r + CW'(1);
        if (last)
          cmp_r <= cmp_eq_r ? (eq_r & sum_zero) : lt;
      end
    end
  end

  always_comb begin
    state_nx  = state_r;
    busy      = 1'b0;
    start_acc = 1'b0;
    last      = 1'b0;
    case (state_r)
      IDLE: begin
        if (alu.i_start) begin
          state_nx  = RUN;
          start_acc = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_r == LAST) begin
          last     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath for the chunk currently on the operand lanes.
  always_comb begin
    b_inv     = alu.i_op_b ^ {W{sub_r}};
    add_full  = {1'b0, alu.i_rs1} + {1'b0, b_inv} + (W+1)'(carry_r);
    sum       = add_full[W-1:0];
    cy        = add_full[W];
    sum_zero  = (sum == '0);
    // Sign-extend the top chunk by one bit; LSB of that extra-bit sum is the borrow sign.
    rs1_sx    = alu.i_rs1[W-1] & cmp_sig_r;
    b_sx      = alu.i_op_b[W-1] & cmp_sig_r;
    lt        = rs1_sx ^ ~b_sx ^ cy;
    bool_res  = ((alu.i_rs1 ^ alu.i_op_b) & {W{~bool_op_r[0]}})
              | ({W{bool_op_r[1]}} & alu.i_rs1 & alu.i_op_b);
    sel1_term = (rd_sel_r[1] && cnt_r == '0) ? W'(cmp_r) : '0;
    rd_run    = (rd_sel_r[0] ? sum : '0) | (rd_sel_r[2] ? bool_res : '0) | sel1_term;
  end

  assign alu.o_rd   = alu.i_buf | (busy ? rd_run : '0);
  assign alu.o_busy = busy;
  assign alu.o_cnt  = cnt_r;
  assign alu.o_done = done_r;
  assign alu.o_cmp  = cmp_r;
endmodule

// File: tb/tb_serv_alu_wide.sv
// Directed checks of serv_alu_wide at W=2, 4 and 8 using hand-computed results.
module tb_serv_alu_wide;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serv_alu_wide_if #(.W(2)) if2 ();
  serv_alu_wide_if #(.W(4)) if4 ();
  serv_alu_wide_if #(.W(8)) if8 ();

  serv_alu_wide #(.W(2)) u2 (.clk(clk), .i_rst(rst), .alu(if2));
  serv_alu_wide #(.W(4)) u4 (.clk(clk), .i_rst(rst), .alu(if4));
  serv_alu_wide #(.W(8)) u8 (.clk(clk), .i_rst(rst), .alu(if8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ctl(input int w, input logic st, input logic sub, input logic [1:0] bop,
                         input logic eq, input logic sig, input logic [2:0] sel);
    case (w)
      2: begin if2.i_start = st; if2.i_sub = sub; if2.i_bool_op = bop;
               if2.i_cmp_eq = eq; if2.i_cmp_sig = sig; if2.i_rd_sel = sel; end
      4: begin if4.i_start = st; if4.i_sub = sub; if4.i_bool_op = bop;
               if4.i_cmp_eq = eq; if4.i_cmp_sig = sig; if4.i_rd_sel = sel; end
      default: begin if8.i_start = st; if8.i_sub = sub; if8.i_bool_op = bop;
               if8.i_cmp_eq = eq; if8.i_cmp_sig = sig; if8.i_rd_sel = sel; end
    endcase
  endtask

  task automatic set_data(input int w, input logic [7:0] a, input logic [7:0] b, input logic [7:0] bv);
    case (w)
      2: begin if2.i_rs1 = a[1:0]; if2.i_op_b = b[1:0]; if2.i_buf = bv[1:0]; end
      4: begin if4.i_rs1 = a[3:0]; if4.i_op_b = b[3:0]; if4.i_buf = bv[3:0]; end
      default: begin if8.i_rs1 = a; if8.i_op_b = b; if8.i_buf = bv; end
    endcase
  endtask

  function automatic logic [7:0] get_rd(input int w);
    case (w)
      2: return {6'b0, if2.o_rd};
      4: return {4'b0, if4.o_rd};
      default: return if8.o_rd;
    endcase
  endfunction

  function automatic logic [7:0] get_cnt(input int w);
    case (w)
      2: return {4'b0, if2.o_cnt};
      4: return {5'b0, if4.o_cnt};
      default: return {6'b0, if8.o_cnt};
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      2: return if2.o_busy;
      4: return if4.o_busy;
      default: return if8.o_busy;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      2: return if2.o_done;
      4: return if4.o_done;
      default: return if8.o_done;
    endcase
  endfunction

  function automatic logic get_cmp(input int w);
    case (w)
      2: return if2.o_cmp;
      4: return if4.o_cmp;
      default: return if8.o_cmp;
    endcase
  endfunction

  // One full operation; midstart >= 0 pulses i_start with inverted controls at that chunk.
  task automatic run_op(input int w, input logic sub, input logic [1:0] bop, input logic eq,
                        input logic sig, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] bv,
                        input int midstart,
                        output logic [31:0] rd, output int ncyc, output int ndone, output logic cmp);
    logic [31:0] mask;
    mask  = (32'd1 << w) - 32'd1;
    rd    = '0;
    ncyc  = 0;
    ndone = 0;
    @(negedge clk);
    set_ctl(w, 1'b1, sub, bop, eq, sig, sel);
    @(negedge clk);
    set_ctl(w, 1'b0, sub, bop, eq, sig, sel);
    for (int k = 0; k < 40; k++) begin
      if (!get_busy(w)) break;
      if (k == midstart)
        set_ctl(w, 1'b1, ~sub, ~bop, ~eq, ~sig, ~sel);
      else if (k == midstart + 1)
        set_ctl(w, 1'b0, ~sub, ~bop, ~eq, ~sig, ~sel);
      set_data(w, 8'((a >> (k * w)) & mask), 8'((b >> (k * w)) & mask), 8'((bv >> (k * w)) & mask));
      #1;
      chk("cnt", 32'(get_cnt(w)), 32'(k));
      rd = rd | (32'(get_rd(w)) << (k * w));
      ndone += int'(get_done(w));
      @(negedge clk);
      ncyc++;
    end
    set_ctl(w, 1'b0, sub, bop, eq, sig, sel);
    chk("done_after_last", 32'(get_done(w)), 32'd1);
    ndone += int'(get_done(w));
    cmp = get_cmp(w);
    @(negedge clk);
    ndone += int'(get_done(w));
  endtask

  logic [31:0] rd;
  int          ncyc, ndone;
  logic        cmp;

  initial begin
    set_ctl(2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000);
    set_ctl(4, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000);
    set_ctl(8, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000);
    set_data(2, 8'h0, 8'h0, 8'h0);
    set_data(4, 8'h0, 8'h0, 8'h3);
    set_data(8, 8'h0, 8'h0, 8'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(get_busy(4)), 32'd0);
    chk("rst_done", 32'(get_done(4)), 32'd0);
    chk("rst_cmp",  32'(get_cmp(4)),  32'd0);
    chk("rst_cnt",  32'(get_cnt(4)),  32'd0);
    chk("idle_rd_is_buf", 32'(get_rd(4)), 32'h3);
    chk("rst_busy_w8", 32'(get_busy(8)), 32'd0);
    set_data(4, 8'h0, 8'h0, 8'h0);

    // Boolean ops, W=4
    run_op(4, 1'b0, 2'b10, 1'b0, 1'b0, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, -1, rd, ncyc, ndone, cmp);
    chk("bool_or", rd, 32'hFFF0FFF0);
    run_op(4, 1'b0, 2'b11, 1'b0, 1'b0, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, -1, rd, ncyc, ndone, cmp);
    chk("bool_and", rd, 32'hF000F000);
    run_op(4, 1'b0, 2'b00, 1'b0, 1'b0, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, -1, rd, ncyc, ndone, cmp);
    chk("bool_xor", rd, 32'h0FF00FF0);
    run_op(4, 1'b0, 2'b01, 1'b0, 1'b0, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hAAAAAAAA, -1, rd, ncyc, ndone, cmp);
    chk("bool_zero_buf", rd, 32'hAAAAAAAA);

    // Signed SLT 5 < 7, W=4
    run_op(4, 1'b1, 2'b00, 1'b0, 1'b1, 3'b001, 32'd5, 32'd7, 32'h0, -1, rd, ncyc, ndone, cmp);
    chk("sub_w4_rd", rd, 32'hFFFFFFFE);
    chk("sub_w4_cycles", 32'(ncyc), 32'd8);
    chk("sub_w4_done_count", 32'(ndone), 32'd1);
    chk("slt_w4_cmp", 32'(cmp), 32'd1);

    // -1 vs 1 unsigned and signed, W=8
    run_op(8, 1'b1, 2'b00, 1'b0, 1'b0, 3'b001, 32'hFFFFFFFF, 32'd1, 32'h0, -1, rd, ncyc, ndone, cmp);
    chk("sltu_w8_rd", rd, 32'hFFFFFFFE);
    chk("sltu_w8_cycles", 32'(ncyc), 32'd4);
    chk("sltu_w8_cmp", 32'(cmp), 32'd0);
    run_op(8, 1'b1, 2'b00, 1'b0, 1'b1, 3'b001, 32'hFFFFFFFF, 32'd1, 32'h0, -1, rd, ncyc, ndone, cmp);
    chk("slt_w8_cmp", 32'(cmp), 32'd1);

    // Equality, W=2
    run_op(2, 1'b1, 2'b00, 1'b1, 1'b0, 3'b001, 32'h1234ABCD, 32'h1234ABCD, 32'h0, -1, rd, ncyc, ndone, cmp);
    chk("eq_w2_rd", rd, 32'h0);
    chk("eq_w2_cycles", 32'(ncyc), 32'd16);
    chk("eq_w2_cmp", 32'(cmp), 32'd1);
    run_op(2, 1'b1, 2'b00, 1'b1, 1'b0, 3'b001, 32'h1234ABCD, 32'h1234ABCC, 32'h0, -1, rd, ncyc, ndone, cmp);
    chk("ne_w2_rd", rd, 32'h1);
    chk("ne_w2_cmp", 32'(cmp), 32'd0);

    // SLT two-pass, W=8
    run_op(8, 1'b1, 2'b00, 1'b0, 1'b1, 3'b001, 32'd3, 32'd5, 32'h0, -1, rd, ncyc, ndone, cmp);
    chk("slt_pass1_cmp", 32'(cmp), 32'd1);
    run_op(8, 1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 32'd5, 32'd3, 32'h0, -1, rd, ncyc, ndone, cmp);
    chk("slt_pass2_rd", rd, 32'h00000001);
    chk("slt_pass2_cmp", 32'(cmp), 32'd0);
    run_op(8, 1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 32'd5, 32'd3, 32'h0, -1, rd, ncyc, ndone, cmp);
    chk("slt_pass3_rd", rd, 32'h00000000);

    // Reset mid-operation, W=4
    @(negedge clk);
    set_ctl(4, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 3'b001);
    @(negedge clk);
    set_ctl(4, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 3'b001);
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      set_data(4, 8'h5 >> (4 * k), 8'h7 >> (4 * k), 8'h0);
      if (k == 3) rst = 1'b1;
      #1;
      ndone += int'(get_done(4));
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(get_busy(4)), 32'd0);
    chk("midrst_cmp",  32'(get_cmp(4)),  32'd0);
    chk("midrst_cnt",  32'(get_cnt(4)),  32'd0);
    ndone += int'(get_done(4));
    @(negedge clk);
    ndone += int'(get_done(4));
    chk("midrst_no_done", 32'(ndone), 32'd0);

    run_op(4, 1'b1, 2'b00, 1'b0, 1'b1, 3'b001, 32'd5, 32'd7, 32'h0, 3, rd, ncyc, ndone, cmp);
    chk("post_rst_rd", rd, 32'hFFFFFFFE);
    chk("post_rst_cycles", 32'(ncyc), 32'd8);
    chk("post_rst_done_count", 32'(ndone), 32'd1);
    chk("post_rst_cmp", 32'(cmp), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
